// File: rtl/simd_pem_reader.sv
// Read sequencer for the three-lane SIMD PEMs. It walks an address window on all lanes in lockstep,
// reading two consecutive words per lane per beat, and streams 48-bit beats through a 2-entry fall-through FIFO.
`timescale 1ns/1ps

module simd_pem_reader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [3:0]          num_beats,
    output logic                busy,
    output logic                done,
    output logic                en_read,
    output logic [ADDR_W-1:0]   reg_read_addr1,
    output logic [ADDR_W-1:0]   reg_read_addr2,
    output logic [ADDR_W-1:0]   reg_read_addr3,
    output logic [ADDR_W-1:0]   reg_read_addr4,
    output logic [ADDR_W-1:0]   reg_read_addr5,
    output logic [ADDR_W-1:0]   reg_read_addr6,
    input  logic [DATA_W-1:0]   reg_read_data1,
    input  logic [DATA_W-1:0]   reg_read_data2,
    input  logic [DATA_W-1:0]   reg_read_data3,
    input  logic [DATA_W-1:0]   reg_read_data4,
    input  logic [DATA_W-1:0]   reg_read_data5,
    input  logic [DATA_W-1:0]   reg_read_data6,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [6*DATA_W-1:0] out_data
);

    localparam int BEAT_W = 6 * DATA_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [ADDR_W-1:0]   addr_a_q;
    logic [ADDR_W-1:0]   addr_b_q;
    logic [3:0]          beats_left_q;
    logic                busy_q;
    logic                done_q;
    logic                inflight_q;
    logic [1:0]          count_q;
    logic [BEAT_W-1:0]   buf0_q;
    logic [BEAT_W-1:0]   buf1_q;

    logic [BEAT_W-1:0]   beat_in;
    logic                push;
    logic                pop;
    logic                issue;
    logic                drain_done;
    logic [2:0]          occ_after;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;

    function automatic logic [3:0] clamp_beats(input logic [3:0] n);
        if (n == 4'd0)
            return 4'd1;
        if (n > 4'(MAX_BEATS))
            return 4'(MAX_BEATS);
        return n;
    endfunction

    assign beat_in = {reg_read_data6, reg_read_data5, reg_read_data4,
                      reg_read_data3, reg_read_data2, reg_read_data1};

    // The read issued last cycle lands now; with an empty buffer it bypasses straight to the output.
    assign push      = inflight_q;
    assign out_valid = (count_q != 2'd0) || inflight_q;
    assign pop       = out_valid && out_ready;
    assign out_data  = (count_q != 2'd0) ? buf0_q : (inflight_q ? beat_in : '0);

    // Entries held after this cycle's capture and pop; a new read may only be issued if it will fit.
    assign occ_after  = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    assign issue      = (state_q == ISSUE) && (occ_after < 3'd2);
    assign drain_done = (state_q == DRAIN) && (occ_after == 3'd0);

    assign addr_a  = issue ? cur_addr_q : addr_a_q;
    assign addr_b  = issue ? (cur_addr_q + ADDR_W'(1)) : addr_b_q;
    assign en_read = issue;
    assign busy    = busy_q;
    assign done    = done_q;

    assign reg_read_addr1 = addr_a;
    assign reg_read_addr2 = addr_b;
    assign reg_read_addr3 = addr_a;
    assign reg_read_addr4 = addr_b;
    assign reg_read_addr5 = addr_a;
    assign reg_read_addr6 = addr_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            beats_left_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            count_q    <= occ_after[1:0];
            if (issue) begin
                addr_a_q <= cur_addr_q;
                addr_b_q <= cur_addr_q + ADDR_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_addr_q   <= base_addr;
                        beats_left_q <= clamp_beats(num_beats);
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        cur_addr_q   <= cur_addr_q + ADDR_W'(2);
                        beats_left_q <= beats_left_q - 4'd1;
                        if (beats_left_q == 4'd1)
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer payload carries no reset; out_data is forced to zero whenever nothing is valid.
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0)
                    buf0_q <= beat_in;
                else
                    buf1_q <= beat_in;
            end
            2'b01: buf0_q <= buf1_q;
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_q <= beat_in;
                end else if (count_q == 2'd2) begin
                    buf0_q <= buf1_q;
                    buf1_q <= beat_in;
                end
            end
            default: ;
        endcase
    end

endmodule
